// File: rtl/tmds_pkg.sv
// Shared TMDS/TERC4 definitions for the HDMI channel encoder and decoder.
// Holds the mode encodings, every fixed 10-bit code word (control, TERC4,
// guard bands), the stage-1 pipeline record and small helper functions.
// Code words are written as Verilog values; bit 0 is transmitted first.
package tmds_pkg;

    // Symbol kinds as they arrive on the mode port. Encodings 5-7 are folded
    // onto MODE_CTRL when the input is registered.
    typedef enum logic [2:0] {
        MODE_CTRL   = 3'd0,
        MODE_VIDEO  = 3'd1,
        MODE_TERC4  = 3'd2,
        MODE_VGUARD = 3'd3,
        MODE_DGUARD = 3'd4
    } mode_e;

    // Control-period symbols, indexed by {vsync,hsync}.
    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    // TERC4 data-island symbols.
    localparam logic [9:0] TERC4_0 = 10'b1010011100;
    localparam logic [9:0] TERC4_1 = 10'b1001100011;
    localparam logic [9:0] TERC4_2 = 10'b1011100100;
    localparam logic [9:0] TERC4_3 = 10'b1011100010;
    localparam logic [9:0] TERC4_4 = 10'b0101110001;
    localparam logic [9:0] TERC4_5 = 10'b0100011110;
    localparam logic [9:0] TERC4_6 = 10'b0110001110;
    localparam logic [9:0] TERC4_7 = 10'b0100111100;
    localparam logic [9:0] TERC4_8 = 10'b1011001100;
    localparam logic [9:0] TERC4_9 = 10'b0100111001;
    localparam logic [9:0] TERC4_A = 10'b0110011100;
    localparam logic [9:0] TERC4_B = 10'b1011000110;
    localparam logic [9:0] TERC4_C = 10'b1010001110;
    localparam logic [9:0] TERC4_D = 10'b1001110001;
    localparam logic [9:0] TERC4_E = 10'b0101100011;
    localparam logic [9:0] TERC4_F = 10'b1011000011;

    // Guard bands. The video guard differs on the green channel (inverted
    // pattern); the data-island guard is fixed on channels 1 and 2.
    localparam logic [9:0] GUARD_VIDEO_B = 10'b1011001100;
    localparam logic [9:0] GUARD_VIDEO_G = 10'b0100110011;
    localparam logic [9:0] GUARD_DATA    = 10'b0100110011;

    // Stage-1 pipeline record: transition-minimised word plus the
    // side-band fields needed by stage 2.
    typedef struct packed {
        logic [8:0] q_m;
        mode_e      mode;
        logic [1:0] sync;
        logic [3:0] ctrl;
    } stage1_t;

    localparam stage1_t STAGE1_RESET = '{q_m: 9'd0, mode: MODE_CTRL, sync: 2'b00, ctrl: 4'd0};

    // Map the raw mode field onto a legal kind; unused codes act as CTRL.
    function automatic mode_e decode_mode(input logic [2:0] m);
        case (m)
            3'd1:    return MODE_VIDEO;
            3'd2:    return MODE_TERC4;
            3'd3:    return MODE_VGUARD;
            3'd4:    return MODE_DGUARD;
            default: return MODE_CTRL;
        endcase
    endfunction

    // First half of TMDS video coding. XNOR chaining is chosen for bytes
    // with many ones so the resulting word has fewer transitions; q_m[8]
    // records which chain was used (1 = XOR).
    function automatic logic [8:0] minimise_transitions(input logic [7:0] d);
        logic [3:0] ones;
        logic       use_xnor;
        logic [8:0] q;
        ones     = 4'($countones(d));
        use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !d[0]);
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic logic [9:0] ctrl_symbol(input logic [1:0] sync);
        case (sync)
            2'b00:   return CTRL_00;
            2'b01:   return CTRL_01;
            2'b10:   return CTRL_10;
            default: return CTRL_11;
        endcase
    endfunction

endpackage

// File: rtl/tmds_encode_terc4_lookup.sv
// Combinational TERC4 table: 4-bit nibble -> 10-bit data-island symbol.
// Ports:
//   nibble  in   4  value to encode
//   symbol  out 10  TERC4 code word (bit 0 transmitted first)
module tmds_terc4_lookup
    import tmds_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [9:0] symbol
);

    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        symbol = TERC4_0;
        case (nibble)
            4'h0: symbol = TERC4_0;
            4'h1: symbol = TERC4_1;
            4'h2: symbol = TERC4_2;
            4'h3: symbol = TERC4_3;
            4'h4: symbol = TERC4_4;
            4'h5: symbol = TERC4_5;
            4'h6: symbol = TERC4_6;
            4'h7: symbol = TERC4_7;
            4'h8: symbol = TERC4_8;
            4'h9: symbol = TERC4_9;
            4'hA: symbol = TERC4_A;
            4'hB: symbol = TERC4_B;
            4'hC: symbol = TERC4_C;
            4'hD: symbol = TERC4_D;
            4'hE: symbol = TERC4_E;
            4'hF: symbol = TERC4_F;
            default: symbol = TERC4_0;
        endcase
    end

endmodule

// File: rtl/tmds_encode.sv
// Transmit-side TMDS/TERC4 encoder for one HDMI channel. One 10-bit symbol
// per clock, two register stages for every symbol kind so mode switches
// never create bubbles or misalignment.
// Parameter:
//   CHANNEL    0=blue, 1=green, 2=red; selects guard-band patterns
// Ports:
//   clk        symbol clock
//   reset_n    asynchronous active-low reset
//   mode   [2:0] symbol kind (CTRL, VIDEO, TERC4, VGUARD, DGUARD; 5-7 = CTRL)
//   data   [7:0] pixel byte (VIDEO)
//   sync   [1:0] {vsync,hsync} (CTRL, and DGUARD on channel 0)
//   ctrl   [3:0] TERC4 nibble (TERC4)
//   out    [9:0] encoded symbol, bit 0 transmitted first
//   disparity [4:0] signed running disparity of the video stream
module tmds_encode
    import tmds_pkg::*;
#(
    parameter int CHANNEL = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        mode,
    input  logic [7:0]        data,
    input  logic [1:0]        sync,
    input  logic [3:0]        ctrl,
    output logic [9:0]        out,
    output logic signed [4:0] disparity
);

    // ---------------- stage 1: transition minimisation ----------------
    stage1_t s1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: every pipeline register is reset so the line carries a legal CTRL symbol straight out of reset.
            s1 <= STAGE1_RESET;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
            s1 <= '{q_m:  minimise_transitions(data),
                    mode: decode_mode(mode),
                    sync: sync,
                    ctrl: ctrl};
        end
    end

    // ---------------- stage 2: DC balance and symbol select ----------------
    logic [9:0]        terc4_sym;
    logic [3:0]        terc4_nibble;
    logic              q8;
    logic [7:0]        q_word;
    logic [3:0]        n1;
    logic signed [5:0] balance;   // n1 - n0 of q_m[7:0]
    logic signed [5:0] cnt_ext;   // disparity widened to hold intermediate sums
    logic signed [5:0] sum;
    logic [9:0]        out_next;

    // Channel-0 data-island guard carries sync as TERC4 of {2'b11, sync}.
    assign terc4_nibble = (s1.mode == MODE_DGUARD) ? {2'b11, s1.sync} : s1.ctrl;

    tmds_terc4_lookup u_terc4 (
        .nibble (terc4_nibble),
        .symbol (terc4_sym)
    );

    assign q8      = s1.q_m[8];
    assign q_word  = s1.q_m[7:0];
    assign n1      = 4'($countones(q_word));
    assign balance = $signed({1'b0, n1, 1'b0}) - 6'sd8;
    assign cnt_ext = {disparity[4], disparity};

    always_comb begin
        out_next = CTRL_00;
        sum      = 6'sd0;   // stays zero for every non-video symbol
        case (s1.mode)
            MODE_VIDEO: begin
                if ((disparity == 5'sd0) || (balance == 6'sd0)) begin
                    // Neutral case: invert only when the XNOR chain was used.
                    out_next = {~q8, q8, q8 ? q_word : ~q_word};
                    sum      = q8 ? (cnt_ext + balance) : (cnt_ext - balance);
                end else if (((disparity > 5'sd0) && (balance > 6'sd0)) ||
                             ((disparity < 5'sd0) && (balance < 6'sd0))) begin
                    // Word would push disparity further the same way: invert it.
                    out_next = {1'b1, q8, ~q_word};
                    sum      = cnt_ext + (q8 ? 6'sd2 : 6'sd0) - balance;
                end else begin
                    out_next = {1'b0, q8, q_word};
                    sum      = cnt_ext - (q8 ? 6'sd0 : 6'sd2) + balance;
                end
            end
            MODE_TERC4:  out_next = terc4_sym;
            MODE_VGUARD: out_next = (CHANNEL == 1) ? GUARD_VIDEO_G : GUARD_VIDEO_B;
            MODE_DGUARD: out_next = (CHANNEL == 0) ? terc4_sym : GUARD_DATA;
            default:     out_next = ctrl_symbol(s1.sync);
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out       <= CTRL_00;
            disparity <= 5'sd0;
        end else begin
            out       <= out_next;
            // Running disparity stays within -8..+8, so five bits suffice.
            disparity <= $signed(sum[4:0]);
        end
    end

endmodule
